// File: rtl/ac_pkg.sv
// Shared types for the AC plant control blocks: scheduler state and plant mode.
package ac_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } ac_state_t;

    typedef enum logic {
        MODE_HEAT = 1'b0,
        MODE_COOL = 1'b1
    } ac_mode_t;
endpackage

// File: rtl/ac_zone_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of valid searching upward from start,
// wrapping; with excl_last the zone just before start (the current holder) is skipped.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    input  logic          excl_last,
    output logic          found,
    output logic [IW-1:0] idx
);
    always_comb begin
        int j;
        logic [IW-1:0] jj;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        // Descending scan so the candidate nearest start overwrites the others.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            jj = IW'(j);
            if (valid[jj] && !(excl_last && k == N - 1)) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end
endmodule

// File: rtl/ac_zone_scheduler.sv
// Shares one heat/cool plant between thermostat zones: round-robin grants with
// minimum/maximum run times and a plant-off dead time on changeover or shutdown.
module ac_zone_scheduler
    import ac_pkg::*;
#(
    parameter int N_ZONES   = 4,
    parameter int MIN_RUN   = 8,
    parameter int MAX_RUN   = 32,
    parameter int DEAD_TIME = 4,
    localparam int IW = $clog2(N_ZONES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ZONES-1:0] heat_req,
    input  logic [N_ZONES-1:0] cool_req,
    output logic               plant_heat,
    output logic               plant_cool,
    output logic [N_ZONES-1:0] zone_open,
    output logic [IW-1:0]      grant_idx,
    output logic [N_ZONES-1:0] conflict,
    output ac_state_t          dbg_state
);
    localparam int RW = $clog2(MAX_RUN + 1);
    localparam int DW = $clog2(DEAD_TIME + 1);
    localparam logic [RW-1:0] MIN_LAST  = RW'(MIN_RUN - 1);
    localparam logic [RW-1:0] MAX_LAST  = RW'(MAX_RUN - 1);
    localparam logic [RW-1:0] MAX_SAT   = RW'(MAX_RUN);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TIME - 1);
    localparam logic [IW-1:0] LAST_ZONE = IW'(N_ZONES - 1);

    ac_state_t          state;
    ac_mode_t           mode;
    logic [RW-1:0]      run_cnt;
    logic [DW-1:0]      dead_cnt;
    logic [N_ZONES-1:0] valid;
    logic [IW-1:0]      start;
    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    ac_mode_t           pick_mode;
    logic               cur_want;
    logic               min_done;
    logic               max_done;
    logic               grant_end;

    assign valid = heat_req ^ cool_req;
    assign start = (grant_idx == LAST_ZONE) ? '0 : grant_idx + 1'b1;

    rr_pick #(.N(N_ZONES)) u_pick (
        .valid     (valid),
        .start     (start),
        .excl_last (state == RUN),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    assign pick_mode = heat_req[pick_idx] ? MODE_HEAT : MODE_COOL;
    // A conflicting or mode-flipped holder counts as no longer requesting.
    assign cur_want  = valid[grant_idx] &&
                       ((mode == MODE_HEAT) ? heat_req[grant_idx] : cool_req[grant_idx]);
    assign min_done  = run_cnt >= MIN_LAST;
    assign max_done  = run_cnt >= MAX_LAST;
    assign grant_end = min_done && (!cur_want || (max_done && pick_found));
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= MODE_HEAT;
            run_cnt    <= '0;
            dead_cnt   <= '0;
            plant_heat <= 1'b0;
            plant_cool <= 1'b0;
            zone_open  <= '0;
            grant_idx  <= LAST_ZONE;
            conflict   <= '0;
        end else begin
            conflict <= heat_req & cool_req;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state      <= RUN;
                        mode       <= pick_mode;
                        plant_heat <= (pick_mode == MODE_HEAT);
                        plant_cool <= (pick_mode == MODE_COOL);
                        zone_open  <= N_ZONES'(1) << pick_idx;
                        grant_idx  <= pick_idx;
                        run_cnt    <= '0;
                    end
                end
                RUN: begin
                    if (grant_end) begin
                        if (pick_found && pick_mode == mode) begin
                            zone_open <= N_ZONES'(1) << pick_idx;
                            grant_idx <= pick_idx;
                            run_cnt   <= '0;
                        end else begin
                            state      <= DEAD;
                            plant_heat <= 1'b0;
                            plant_cool <= 1'b0;
                            zone_open  <= '0;
                            dead_cnt   <= '0;
                        end
                    end else if (max_done && !pick_found) begin
                        run_cnt <= '0;
                    end else if (run_cnt != MAX_SAT) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                DEAD: begin
                    if (dead_cnt >= DEAD_LAST) state <= IDLE;
                    else dead_cnt <= dead_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ac_zone_scheduler.sv
// Bench for ac_zone_scheduler: directed scenarios plus random requests, every cycle's
// outputs scored against a grant-level reference model.
module tb_ac_zone_scheduler;
    import ac_pkg::*;

    localparam int N         = 4;
    localparam int MIN_RUN   = 8;
    localparam int MAX_RUN   = 32;
    localparam int DEAD_TIME = 4;
    localparam int IW        = 2;
    localparam int OW        = 2 + N + IW + N;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   heat_req = '0;
    logic [N-1:0]   cool_req = '0;
    logic           plant_heat;
    logic           plant_cool;
    logic [N-1:0]   zone_open;
    logic [IW-1:0]  grant_idx;
    logic [N-1:0]   conflict;
    ac_state_t      dbg_state;

    int tests = 0;
    int fails = 0;
    logic [OW-1:0] exp_q[$];

    // Reference model: phase 0 = plant free, 1 = zone holds plant, 2 = plant resting.
    int           m_phase;
    int           m_zone;
    int           m_age;
    int           m_rest;
    bit           m_heat;
    logic [N-1:0] m_conf;

    ac_zone_scheduler #(
        .N_ZONES(N), .MIN_RUN(MIN_RUN), .MAX_RUN(MAX_RUN), .DEAD_TIME(DEAD_TIME)
    ) dut (
        .clk(clk), .rst(rst), .heat_req(heat_req), .cool_req(cool_req),
        .plant_heat(plant_heat), .plant_cool(plant_cool), .zone_open(zone_open),
        .grant_idx(grant_idx), .conflict(conflict), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic int rr_next(input int from, input bit excl, input logic [N-1:0] v);
        int z;
        for (int k = 1; k <= N; k++) begin
            z = (from + k) % N;
            if (!(excl && z == from) && v[z]) return z;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input logic [N-1:0] h, input logic [N-1:0] c);
        logic [N-1:0] v;
        bit want;
        int nxt;
        v = h ^ c;
        if (r) begin
            m_phase = 0; m_zone = N - 1; m_age = 0; m_rest = 0; m_heat = 1'b1; m_conf = '0;
            return;
        end
        m_conf = h & c;
        if (m_phase == 0) begin
            nxt = rr_next(m_zone, 1'b0, v);
            if (nxt >= 0) begin
                m_phase = 1; m_zone = nxt; m_heat = h[nxt]; m_age = 1;
            end
        end else if (m_phase == 1) begin
            want = m_heat ? (h[m_zone] && !c[m_zone]) : (c[m_zone] && !h[m_zone]);
            nxt  = rr_next(m_zone, 1'b1, v);
            if (m_age >= MIN_RUN && (!want || (m_age >= MAX_RUN && nxt >= 0))) begin
                if (nxt >= 0 && h[nxt] == m_heat) begin
                    m_zone = nxt; m_age = 1;
                end else begin
                    m_phase = 2; m_rest = DEAD_TIME;
                end
            end else if (m_age >= MAX_RUN) begin
                m_age = 1;
            end else begin
                m_age++;
            end
        end else begin
            m_rest--;
            if (m_rest == 0) m_phase = 0;
        end
    endtask

    function automatic logic [OW-1:0] model_out();
        logic ph, pc;
        logic [N-1:0] zo;
        ph = (m_phase == 1) && m_heat;
        pc = (m_phase == 1) && !m_heat;
        zo = (m_phase == 1) ? (N'(1) << m_zone) : '0;
        return {ph, pc, zo, IW'(m_zone), m_conf};
    endfunction

    task automatic drive(input bit r, input logic [N-1:0] h, input logic [N-1:0] c);
        @(negedge clk);
        rst = r; heat_req = h; cool_req = c;
        model_step(r, h, c);
        exp_q.push_back(model_out());
    endtask

    initial begin
        logic [OW-1:0] exp_v;
        logic [OW-1:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            tests++;
            if (plant_heat && plant_cool) begin
                fails++;
                $display("FAIL plant_exclusive t=%0t got heat=%b cool=%b, need not both 1",
                         $time, plant_heat, plant_cool);
            end
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {plant_heat, plant_cool, zone_open, grant_idx, conflict};
                tests++;
                if (act_v !== exp_v) begin
                    fails++;
                    $display("FAIL outputs t=%0t got=%b expected=%b (heat,cool,zone_open,grant_idx,conflict) state=%0d",
                             $time, act_v, exp_v, dbg_state);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] h;
        logic [N-1:0] c;
        bit r;
        repeat (2) drive(1'b1, '0, '0);
        // Short request: held for MIN_RUN, then dead time.
        repeat (2)  drive(1'b0, 4'b0001, '0);
        repeat (14) drive(1'b0, '0, '0);
        // Two heating zones: MAX_RUN pre-emption and hand-over without plant gap.
        repeat (70) drive(1'b0, 4'b0101, '0);
        repeat (8)  drive(1'b0, '0, '0);
        // Heat to cool changeover through dead time and one idle cycle.
        repeat (10) drive(1'b0, 4'b0001, '0);
        repeat (20) drive(1'b0, '0, 4'b0010);
        repeat (8)  drive(1'b0, '0, '0);
        // Conflicting requests never enable the plant.
        repeat (5)  drive(1'b0, 4'b0001, 4'b0001);
        repeat (2)  drive(1'b0, '0, '0);
        // Reset in the middle of a run, request still held.
        repeat (5)  drive(1'b0, 4'b0001, '0);
        drive(1'b1, 4'b0001, '0);
        repeat (3)  drive(1'b0, 4'b0001, '0);
        repeat (14) drive(1'b0, '0, '0);
        // Random requests with slowly changing levels and rare resets.
        h = '0;
        c = '0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                h = N'($urandom);
                c = N'($urandom);
                if ($urandom_range(0, 3) != 0) c = c & ~h;
            end
            r = ($urandom_range(0, 299) == 0);
            drive(r, h, c);
        end
        repeat (2) drive(1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expectations, need 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
